// File: rtl/store_narrow_buf_pkg.sv
// Shared definitions for the store narrowing buffer: size encodings,
// drain FSM states and the lane-aligned payload carried by each entry.
package store_narrow_buf_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Lane-aligned write data and byte enables; the top pairs this with an
  // AW-wide word address to form a buffer entry.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } lane_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational narrowing of a 32-bit store onto byte lanes with byte
// enables; flags misaligned halfword/word stores and the reserved size.
module store_lane_align
  import store_narrow_buf_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // Replicate the narrowed value across all lanes; be selects the live ones.
  always_comb begin
    be       = '0;
    wdata    = '0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{data[15:0]}};
        misalign = addr[0];
      end
      SZ_WORD: begin
        be       = '1;
        wdata    = data;
        misalign = (addr != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrow_buf.sv
// Store narrowing buffer: aligns MEM-stage stores, queues them in a small
// FIFO and drains them to data memory over a req/ack handshake.
// Optional macro STORE_FWD_EN adds ld_addr/ld_hit load-hazard detection.
module store_narrow_buf
  import store_narrow_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_size,
  output logic          st_misalign,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          buf_empty
`ifdef STORE_FWD_EN
  ,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    lane_t         lane;
  } entry_t;

  entry_t         fifo_q [DEPTH];
  entry_t         head_q, head_d, new_e;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_e         state_q, state_d;
  logic           misalign_q;
  logic [3:0]     al_be;
  logic [31:0]    al_data;
  logic           al_mis;
  logic           enq, pop;

  store_lane_align u_align (
    .addr     (st_addr[1:0]),
    .size     (st_size),
    .data     (st_data),
    .be       (al_be),
    .wdata    (al_data),
    .misalign (al_mis)
  );

  // Assemble the entry that an accepted store writes into the FIFO.
  always_comb begin
    new_e           = '0;
    new_e.addr      = {st_addr[AW-1:2], 2'b00};
    new_e.lane.data = al_data;
    new_e.lane.be   = al_be;
  end

  assign st_ready  = (count_q != CW'(DEPTH));
  assign enq       = st_valid & st_ready & ~al_mis;
  assign pop       = (state_q == S_REQ) & mem_ack;
  assign mem_req   = (state_q == S_REQ);
  assign buf_empty = (count_q == '0) & ~mem_req;
  assign mem_addr  = head_q.addr;
  assign mem_wdata = head_q.lane.data;
  assign mem_be    = head_q.lane.be;
  assign st_misalign = misalign_q;

  // Pointer/count bookkeeping and drain FSM next state.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_REQ;
          head_d  = fifo_q[rd_ptr_q];
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          // With one entry left and a same-edge enqueue, the next head is
          // the incoming store, not yet visible in the array.
          if (count_d != '0)
            head_d = (count_q == CW'(1)) ? new_e : fifo_q[rd_ptr_d];
          else
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers, presented request and misalign pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= st_valid & al_mis;
      if (enq) fifo_q[wr_ptr_q] <= new_e;
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] off;
  // Any occupied slot (in-flight head included) matching the load's word.
  always_comb begin
    ld_hit = 1'b0;
    off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) &&
          (((fifo_q[i].addr ^ ld_addr) & ~AW'(3)) == '0))
        ld_hit = 1'b1;
    end
  end
`endif

endmodule

// File: doc/store_narrow_buf.md
Name: store_narrow_buf

Overview:
- Write-side counterpart of the load-path extender: takes 32-bit register store data from the MEM stage and narrows it to byte or halfword.
- Places the narrowed data on the correct byte lanes and generates byte enables.
- Flags misaligned stores.
- Buffers accepted stores in a small FIFO and drains them to data memory over a req/ack handshake, so the pipeline does not stall on memory latency.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2).
- AW, 32, address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  MEM stage presents a store.
- st_ready  output  1  buffer can accept (not full).
- st_addr  input  AW  byte address.
- st_data  input  32  register value (rt).
- st_size  input  2  00=byte (sb), 01=half (sh), 10=word (sw), 11=reserved.
- st_misalign  output  1  one-cycle pulse: presented store was misaligned or had reserved size.
- mem_req  output  1  request to data memory.
- mem_addr  output  AW  word-aligned address (low 2 bits zero).
- mem_wdata  output  32  lane-aligned data.
- mem_be  output  4  byte enables, bit i = byte lane i.
- mem_ack  input  1  memory accepted the current request.
- buf_empty  output  1  no pending stores; used by sync/fence logic.

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, count 0, state IDLE. All outputs after reset: mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_misalign=0, st_ready=1, buf_empty=1.
- Narrowing, combinational on the input side, with k = st_addr[1:0]:
  - byte: be = 1<<k; data = {4{st_data[7:0]}}.
  - half: be = 0011 if k[1]=0, else 1100; data = {2{st_data[15:0]}}.
  - word: be = 1111; data = st_data.
- Alignment rules:
  - half requires st_addr[0]=0; word requires st_addr[1:0]=00; size 11 is always illegal.
  - An illegal store is never enqueued. st_misalign pulses high for the cycle after the st_valid cycle (registered).
- Enqueue: on a rising edge with st_valid & st_ready & aligned, write {addr[AW-1:2],2'b00, data, be} at wr_ptr.
- st_ready = (count != DEPTH). It is combinational from count only, not from st_valid.
- Drain FSM:
  - IDLE: if count>0, go to REQ. mem_* are registered from the head entry on the transition.
  - REQ: mem_req=1 and mem_addr/wdata/be are held stable until mem_ack is sampled high.
  - On ack: pop head. If count after the pop is >0, stay in REQ and load the next head the same edge (back-to-back, one store per cycle at best). Otherwise go to IDLE with mem_req=0.
  - mem_addr/wdata/be retain their last value in IDLE.
- Latency: an enqueue into an empty buffer gives mem_req=1 two edges later (enqueue edge, then IDLE→REQ edge).
- Simultaneous enqueue and pop while full: st_ready is 0 that cycle, so there is no enqueue. Full→full bypass is not supported.
- Simultaneous enqueue and pop otherwise: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- buf_empty = (count==0) & ~mem_req.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-transfer: the in-flight and buffered stores are discarded and all outputs return to reset values immediately (asynchronous).

Optional Feature:
- STORE_FWD_EN defined: adds input ld_addr[AW-1:0] and output ld_hit.
  - ld_hit is combinationally 1 if any valid entry, including the in-flight REQ head, has a matching word address ld_addr[AW-1:2].
  - The hazard unit stalls the load while ld_hit=1. No data forwarding is performed.
- STORE_FWD_EN undefined: neither port exists, and loads rely on the hazard unit draining the buffer via buf_empty.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state constants S_IDLE, S_REQ;
  - the entry struct {addr, data, be}.
- The lane/byte-enable generator is a natural combinational sub-module: store_lane_align (inputs addr[1:0], size, data; outputs be, aligned data, misalign).
- The FIFO and FSM stay in the top module.

Test Plan:
- sb, addr 0x1003, data 0xAABBCCDD, mem_ack tied 1 → mem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, mem_req high exactly 1 cycle, buf_empty returns 1.
- sh at 0x2002, data 0x12345678; then sw at 0x2004, data 0xCAFEF00D, ack delayed 3 cycles → first be=1100/wdata=0x56785678 held stable 3 cycles, then be=1111/0xCAFEF00D. Order is preserved.
- sh at 0x3001, then sw at 0x3002, then size 11 → st_misalign pulses each time, nothing enqueued, mem_req stays 0.
- Three back-to-back sw stores with mem_ack=0 (DEPTH=2):
  - st_ready drops after the second store; the third is held.
  - When ack is raised, entries drain one per cycle and the third enqueues when st_ready returns to 1.
- Reset pulsed while mem_req=1 with 2 entries pending → mem_req=0, buf_empty=1, st_ready=1 immediately. No stale request after reset release.
- STORE_FWD_EN defined: pending sw at 0x4008, ld_addr=0x400A → ld_hit=1. ld_addr=0x400C → ld_hit=0. After the ack drains the entry, ld_hit=0.
